// File: rtl/ddr_arb_pkg.sv
// ---------------------------------------------------------------------------
// ddr_arb_pkg
// Shared definitions for the DDR user-port arbiter:
//   DATA_W_DEF / ADR_W_DEF : default DDR data and address widths
//   state_t                : arbiter FSM encoding (IDLE, ISSUE, WAIT)
//   clog2()                : constant-evaluable ceiling log2 for widths
// ---------------------------------------------------------------------------
package ddr_arb_pkg;

    localparam int DATA_W_DEF = 512;
    localparam int ADR_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_port_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick.
//   i_req     : request vector
//   i_rr_last : index granted last time; the scan starts one above it
//   o_gnt     : one-hot grant (all zero when no request)
//   o_idx     : index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_masked;
    logic [NUM_REQ-1:0] w_pick;

    // Requesters above rr_last get first chance; if none of them is asking,
    // the unmasked vector is used, which is the wrap back to index 0.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (i > int'(i_rr_last));
        end
    end

    assign w_masked = i_req & w_mask;
    assign w_pick   = (|w_masked) ? w_masked : i_req;

    // Lowest set bit of w_pick wins: scanning downward lets the last hit stick.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
                o_idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_port_arbiter
// Shares the single DDR user port between NUM_REQ requesters with
// round-robin arbitration and one outstanding transaction at a time.
// A missing DDR_valid is caught by a timeout that forces completion.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req/req_wr                 : per-requester request level and direction
//   req_adr/req_wdata          : packed per-requester address / write data
//   gnt, done                  : one-hot 1-cycle accept / finish pulses
//   rd_data                    : read data, valid with done of a read
//   timeout_err                : sticky timeout flag (cleared by reset only)
//   DDR_en/DDR_en_wr/DDR_adr/DDR_in : command side of the DDR port
//   DDR_valid/DDR_out          : completion and read data from DDR
// ---------------------------------------------------------------------------
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADR_W   = ADR_W_DEF,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADR_W-1:0]  req_adr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      timeout_err,
    output logic                      DDR_en,
    output logic                      DDR_en_wr,
    output logic [ADR_W-1:0]          DDR_adr,
    output logic [DATA_W-1:0]         DDR_in,
    input  logic                      DDR_valid,
    input  logic [DATA_W-1:0]         DDR_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
    localparam int TMO_W = clog2(TIMEOUT);

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_last;
    logic [NUM_REQ-1:0] r_cur_gnt;
    logic [TMO_W-1:0]   r_tmo_cnt;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req     (req),
        .i_rr_last (r_rr_last),
        .o_gnt     (w_gnt),
        .o_idx     (w_idx)
    );

    // DDR_en_wr/DDR_adr/DDR_in double as the latched payload of the current
    // transaction: they are loaded on acceptance and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_last   <= IDX_W'(NUM_REQ - 1);
            r_cur_gnt   <= '0;
            r_tmo_cnt   <= '0;
            gnt         <= '0;
            done        <= '0;
            rd_data     <= '0;
            timeout_err <= 1'b0;
            DDR_en      <= 1'b0;
            DDR_en_wr   <= 1'b0;
            DDR_adr     <= '0;
            DDR_in      <= '0;
        end else begin
            gnt    <= '0;
            done   <= '0;
            DDR_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_rr_last <= w_idx;
                        r_cur_gnt <= w_gnt;
                        gnt       <= w_gnt;
                        DDR_en    <= 1'b1;
                        DDR_en_wr <= req_wr[w_idx];
                        DDR_adr   <= req_adr[int'(w_idx)*ADR_W +: ADR_W];
                        DDR_in    <= req_wdata[int'(w_idx)*DATA_W +: DATA_W];
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // DDR_valid is deliberately not looked at here.
                    r_tmo_cnt <= '0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    // A reply on the last permitted cycle still wins over timeout.
                    if (DDR_valid) begin
                        if (!DDR_en_wr) begin
                            rd_data <= DDR_out;
                        end
                        done    <= r_cur_gnt;
                        r_state <= IDLE;
                    end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        done        <= r_cur_gnt;
                        r_state     <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_port_arbiter
// Directed bench for ddr_port_arbiter (NUM_REQ=2, TIMEOUT=16). Transactions
// come from a table of hand-computed records; timeout and mid-transaction
// reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_ddr_port_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 512;
    localparam int ADR_W   = 32;
    localparam int TIMEOUT = 16;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADR_W-1:0]  req_adr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rd_data;
    logic                      timeout_err;
    logic                      DDR_en;
    logic                      DDR_en_wr;
    logic [ADR_W-1:0]          DDR_adr;
    logic [DATA_W-1:0]         DDR_in;
    logic                      DDR_valid;
    logic [DATA_W-1:0]         DDR_out;

    ddr_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ADR_W   (ADR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_wr      (req_wr),
        .req_adr     (req_adr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .done        (done),
        .rd_data     (rd_data),
        .timeout_err (timeout_err),
        .DDR_en      (DDR_en),
        .DDR_en_wr   (DDR_en_wr),
        .DDR_adr     (DDR_adr),
        .DDR_in      (DDR_in),
        .DDR_valid   (DDR_valid),
        .DDR_out     (DDR_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic        hold;     // keep req high through the transaction
        logic        glitch;   // DDR_valid high on the IDLE and ISSUE edges
        int          delay;    // edges from DDR_en to the real DDR_valid
        logic [31:0] adr0;
        logic [31:0] adr1;
        logic [7:0]  wd0;
        logic [7:0]  wd1;
        logic [7:0]  reply;
        logic [1:0]  exp_gnt;
        logic        exp_wr;
        logic [31:0] exp_adr;
        logic [7:0]  exp_wd;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[9];

    int n_cmp;
    int n_fail;
    logic [DATA_W-1:0] last_rd;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   gnt,         '0);
        chk({tag, "_done"},  done,        '0);
        chk({tag, "_rd"},    rd_data,     '0);
        chk({tag, "_terr"},  timeout_err, '0);
        chk({tag, "_en"},    DDR_en,      '0);
        chk({tag, "_enwr"},  DDR_en_wr,   '0);
        chk({tag, "_adr"},   DDR_adr,     '0);
        chk({tag, "_in"},    DDR_in,      '0);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        req       = v.req;
        req_wr    = v.wr;
        req_adr   = {v.adr1, v.adr0};
        req_wdata = {{64{v.wd1}}, {64{v.wd0}}};
        if (v.glitch) begin
            DDR_valid = 1'b1;
            DDR_out   = {64{8'hEE}};
        end
        step();
        chk({tag, "_gnt"},  gnt,       v.exp_gnt);
        chk({tag, "_en"},   DDR_en,    1'b1);
        chk({tag, "_enwr"}, DDR_en_wr, v.exp_wr);
        chk({tag, "_adr"},  DDR_adr,   v.exp_adr);
        chk({tag, "_in"},   DDR_in,    {64{v.exp_wd}});
        chk({tag, "_done0"}, done,     '0);
        if (!v.hold) req = '0;
        for (int n = 1; n < v.delay; n++) begin
            step();
            if (n == 1 && v.glitch) begin
                DDR_valid = 1'b0;
                DDR_out   = '0;
            end
            chk({tag, "_wgnt"},  gnt,       '0);
            chk({tag, "_wdone"}, done,      '0);
            chk({tag, "_wen"},   DDR_en,    1'b0);
            chk({tag, "_wenwr"}, DDR_en_wr, v.exp_wr);
            chk({tag, "_wadr"},  DDR_adr,   v.exp_adr);
            chk({tag, "_win"},   DDR_in,    {64{v.exp_wd}});
            chk({tag, "_wrd"},   rd_data,   last_rd);
        end
        DDR_valid = 1'b1;
        DDR_out   = {64{v.reply}};
        step();
        DDR_valid = 1'b0;
        DDR_out   = '0;
        chk({tag, "_done"}, done,    v.exp_gnt);
        chk({tag, "_rd"},   rd_data, {64{v.exp_rd}});
        chk({tag, "_dgnt"}, gnt,     '0);
        last_rd = {64{v.exp_rd}};
    endtask

    initial begin
        int   seen;
        vec_t v;
        n_cmp  = 0;
        n_fail = 0;

        //           req    wr     hld   glt   dly adr0          adr1          wd0    wd1    reply  gnt    wr    adr           wd     rd
        vecs[0] = '{2'b01, 2'b00, 1'b0, 1'b0, 3,  32'h0000_0100, 32'h0000_0999, 8'hC3, 8'h3C, 8'hA5, 2'b01, 1'b0, 32'h0000_0100, 8'hC3, 8'hA5};
        vecs[1] = '{2'b11, 2'b00, 1'b1, 1'b0, 2,  32'h0000_0200, 32'h0000_0300, 8'h01, 8'h02, 8'h11, 2'b10, 1'b0, 32'h0000_0300, 8'h02, 8'h11};
        vecs[2] = '{2'b11, 2'b00, 1'b1, 1'b0, 4,  32'h0000_0200, 32'h0000_0300, 8'h01, 8'h02, 8'h22, 2'b01, 1'b0, 32'h0000_0200, 8'h01, 8'h22};
        vecs[3] = '{2'b11, 2'b00, 1'b1, 1'b0, 3,  32'h0000_0200, 32'h0000_0300, 8'h01, 8'h02, 8'h33, 2'b10, 1'b0, 32'h0000_0300, 8'h02, 8'h33};
        vecs[4] = '{2'b11, 2'b00, 1'b1, 1'b0, 2,  32'h0000_0200, 32'h0000_0300, 8'h01, 8'h02, 8'h44, 2'b01, 1'b0, 32'h0000_0200, 8'h01, 8'h44};
        vecs[5] = '{2'b10, 2'b10, 1'b0, 1'b0, 4,  32'h0000_0000, 32'h0000_0040, 8'h00, 8'h5A, 8'hFF, 2'b10, 1'b1, 32'h0000_0040, 8'h5A, 8'h44};
        vecs[6] = '{2'b01, 2'b00, 1'b0, 1'b1, 2,  32'h0000_0180, 32'h0000_0000, 8'h12, 8'h00, 8'h3C, 2'b01, 1'b0, 32'h0000_0180, 8'h12, 8'h3C};
        vecs[7] = '{2'b10, 2'b00, 1'b0, 1'b0, 17, 32'h0000_0000, 32'h0000_0280, 8'h00, 8'h77, 8'h66, 2'b10, 1'b0, 32'h0000_0280, 8'h77, 8'h66};
        vecs[8] = '{2'b11, 2'b11, 1'b0, 1'b0, 5,  32'h0000_0A00, 32'h0000_0B00, 8'hAA, 8'hBB, 8'h99, 2'b01, 1'b1, 32'h0000_0A00, 8'hAA, 8'h66};

        rst_n     = 1'b0;
        req       = '0;
        req_wr    = '0;
        req_adr   = '0;
        req_wdata = '0;
        DDR_valid = 1'b0;
        DDR_out   = '0;
        last_rd   = '0;
        #1;
        chk_all_zero("reset");
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;

        // Table: basic read, alternation under held req, write, glitches,
        // reply on the final timeout cycle, both requesters writing.
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i], $sformatf("v%0d", i));
        end
        chk("late_valid_terr", timeout_err, 1'b0);

        // Missing reply: done 17 edges after the gnt edge (ISSUE + 16 WAIT).
        req       = 2'b10;
        req_wr    = 2'b00;
        req_adr   = {32'h0000_0600, 32'h0};
        req_wdata = '0;
        step();
        chk("tmo_gnt", gnt, 2'b10);
        req  = '0;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (done != '0) begin
                seen = k;
                break;
            end
        end
        chk("tmo_cycles", seen, 17);
        chk("tmo_done",   done, 2'b10);
        chk("tmo_terr",   timeout_err, 1'b1);
        chk("tmo_rd",     rd_data, last_rd);
        v = '{2'b01, 2'b00, 1'b0, 1'b0, 3, 32'h0000_0700, 32'h0, 8'h00, 8'h00, 8'h9D, 2'b01, 1'b0, 32'h0000_0700, 8'h00, 8'h9D};
        run_txn(v, "after_tmo");
        chk("tmo_sticky", timeout_err, 1'b1);

        // Reset during WAIT aborts silently.
        req       = 2'b01;
        req_wr    = 2'b00;
        req_adr   = {32'h0, 32'h0000_0800};
        step();
        chk("rstw_gnt", gnt, 2'b01);
        req = '0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstw");
        last_rd   = '0;
        DDR_valid = 1'b1;
        DDR_out   = {64{8'h42}};
        step();
        chk("rstw_done_held", done, '0);
        chk("rstw_rd_held",   rd_data, '0);
        DDR_valid = 1'b0;
        DDR_out   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        v = '{2'b11, 2'b00, 1'b0, 1'b0, 2, 32'h0000_0900, 32'h0000_0A00, 8'h01, 8'h02, 8'h5E, 2'b01, 1'b0, 32'h0000_0900, 8'h01, 8'h5E};
        run_txn(v, "post_rst");
        chk("post_rst_terr", timeout_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
